// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared types and helpers for the round-robin arbiter.
//   rr_arb_state_t : FSM state encoding (IDLE / BUSY)
//   oh2idx         : one-hot (up to 32 bits) to 5-bit binary index
//   hi_mask        : bits [31:ptr] set, i.e. the high group for a pointer
package rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } rr_arb_state_t;

    // OR-reduce the indices of set bits; exact for a one-hot input.
    function automatic logic [4:0] oh2idx(input logic [31:0] oh);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            idx = idx | (oh[i] ? 5'(i) : 5'd0);
        end
        return idx;
    endfunction

    // Requesters at or above ptr form the high group.
    function automatic logic [31:0] hi_mask(input logic [4:0] ptr);
        logic [31:0] m;
        m = 32'd0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (5'(i) >= ptr);
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// onehot: isolates a single set bit of a vector.
//   W   : vector width
//   MSB : 0 -> keep lowest set bit, 1 -> keep highest set bit
// Ports:
//   bits  in  W : input vector
//   first out W : one-hot (or zero) result
module onehot #(
    parameter int W   = 4,
    parameter bit MSB = 1'b0
) (
    input  logic [W-1:0] bits,
    output logic [W-1:0] first
);

    generate
        if (MSB) begin : g_msb
            logic [W-1:0] rev_s;
            logic [W-1:0] iso_s;
            for (genvar i = 0; i < W; i++) begin : g_rev
                assign rev_s[i]     = bits[W-1-i];
                assign first[W-1-i] = iso_s[i];
            end
            // Two's complement trick keeps only the lowest set bit.
            assign iso_s = rev_s & (~rev_s + W'(1));
        end else begin : g_lsb
            assign first = bits & (~bits + W'(1));
        end
    endgenerate

endmodule

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter for one shared resource among N requesters.
// Optional feature macro: RR_ARB_TIMEOUT_EN (hold timeout + tmo pulse).
// Parameters:
//   N        : requesters, 2..32
//   HOLD_MAX : maximum ownership in cycles (timeout build only), 1..65535
// Ports:
//   clk     in  1        : clock, rising edge
//   rst_n   in  1        : asynchronous active-low reset
//   req     in  N        : level requests
//   done    in  1        : resource completion pulse, ends ownership
//   gnt     out N        : registered one-hot grant
//   gnt_vld out 1        : registered OR of gnt
//   gnt_idx out clog2(N) : registered index of the owner, 0 when idle
//   tmo     out 1        : registered pulse when a grant is revoked by timeout
module rr_arb
    import rr_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int HOLD_MAX = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 done,
    output logic [N-1:0]         gnt,
    output logic                 gnt_vld,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 tmo
);

    localparam int PW = $clog2(N);

    generate
        if (N < 2 || N > 32 || HOLD_MAX < 1 || HOLD_MAX > 65535) begin : g_bad_param
            $error("rr_arb: N or HOLD_MAX out of range");
        end
    endgenerate

    rr_arb_state_t state_r, state_nxt_s;
    logic [PW-1:0] ptr_r;
    logic [N-1:0]  gnt_r;
    logic          gnt_vld_r;
    logic [PW-1:0] gnt_idx_r;

    logic          timeout_s;
    logic          release_s;
    logic [PW-1:0] ptr_nxt_s;
    logic [PW-1:0] sel_ptr_s;
    logic [N-1:0]  req_eff_s;
    logic [N-1:0]  masked_s;
    logic [N-1:0]  masked_oh_s;
    logic [N-1:0]  plain_oh_s;
    logic [N-1:0]  cand_oh_s;
    logic          cand_vld_s;
    logic          load_s;
    logic          clear_s;

    assign release_s = (state_r == BUSY) && (done || !req[gnt_idx_r] || timeout_s);

    // Wrap explicitly so non-power-of-two N never yields an out-of-range pointer.
    assign ptr_nxt_s = (gnt_idx_r == PW'(N - 1)) ? {PW{1'b0}} : gnt_idx_r + PW'(1);
    assign sel_ptr_s = release_s ? ptr_nxt_s : ptr_r;

    // On release the outgoing owner cannot win the re-selection.
    assign req_eff_s = release_s ? (req & ~gnt_r) : req;
    assign masked_s  = req_eff_s & N'(hi_mask(5'(sel_ptr_s)));

    onehot #(.W(N), .MSB(1'b0)) u_oh_masked (
        .bits  (masked_s),
        .first (masked_oh_s)
    );

    onehot #(.W(N), .MSB(1'b0)) u_oh_plain (
        .bits  (req_eff_s),
        .first (plain_oh_s)
    );

    assign cand_oh_s  = (|masked_oh_s) ? masked_oh_s : plain_oh_s;
    assign cand_vld_s = |req_eff_s;

    // Next-state and grant load/clear decisions.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        clear_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (cand_vld_s) begin
                    state_nxt_s = BUSY;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (release_s && cand_vld_s) begin
                    state_nxt_s = BUSY;
                    load_s      = 1'b1;
                end else if (release_s) begin
                    state_nxt_s = IDLE;
                    clear_s     = 1'b1;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                clear_s     = 1'b1;
            end
        endcase
    end

    // State, pointer and grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= {PW{1'b0}};
            gnt_r     <= {N{1'b0}};
            gnt_vld_r <= 1'b0;
            gnt_idx_r <= {PW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (release_s) begin
                ptr_r <= ptr_nxt_s;
            end else begin
                ptr_r <= ptr_r;
            end
            if (load_s) begin
                gnt_r     <= cand_oh_s;
                gnt_vld_r <= 1'b1;
                gnt_idx_r <= PW'(oh2idx(32'(cand_oh_s)));
            end else if (clear_s) begin
                gnt_r     <= {N{1'b0}};
                gnt_vld_r <= 1'b0;
                gnt_idx_r <= {PW{1'b0}};
            end else begin
                gnt_r     <= gnt_r;
                gnt_vld_r <= gnt_vld_r;
                gnt_idx_r <= gnt_idx_r;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CW = $clog2(HOLD_MAX + 1);
    logic [CW-1:0] hold_cnt_r;
    logic          tmo_r;

    // Ownership age: zero on each new grant, counts every BUSY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= {CW{1'b0}};
        end else if (load_s) begin
            hold_cnt_r <= {CW{1'b0}};
        end else if (state_r == BUSY) begin
            hold_cnt_r <= hold_cnt_r + CW'(1);
        end else begin
            hold_cnt_r <= {CW{1'b0}};
        end
    end

    assign timeout_s = (state_r == BUSY) && (hold_cnt_r == CW'(HOLD_MAX - 1));

    // tmo only when the timeout alone forced the release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_r <= 1'b0;
        end else begin
            tmo_r <= timeout_s && !done && req[gnt_idx_r];
        end
    end

    assign tmo = tmo_r;
`else
    assign timeout_s = 1'b0;
    assign tmo       = 1'b0;
`endif

    assign gnt     = gnt_r;
    assign gnt_vld = gnt_vld_r;
    assign gnt_idx = gnt_idx_r;

endmodule

// File: tb/tb_rr_arb.sv
// tb_rr_arb: directed, table-driven bench for rr_arb (N=4, HOLD_MAX=8).
// The timeout sequence adapts to whether RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arb;

    localparam int N        = 4;
    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic       tmo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rr_arb #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .tmo     (tmo)
    );

    typedef struct packed {
        logic [3:0] req;
        logic       done;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       tmo;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] ei,
                       input logic ev, input logic et);
        checks++;
        if (gnt !== eg) begin
            failures++;
            $display("FAIL %s gnt got=%b exp=%b", nm, gnt, eg);
        end
        checks++;
        if (gnt_idx !== ei) begin
            failures++;
            $display("FAIL %s gnt_idx got=%0d exp=%0d", nm, gnt_idx, ei);
        end
        checks++;
        if (gnt_vld !== ev) begin
            failures++;
            $display("FAIL %s gnt_vld got=%b exp=%b", nm, gnt_vld, ev);
        end
        checks++;
        if (tmo !== et) begin
            failures++;
            $display("FAIL %s tmo got=%b exp=%b", nm, tmo, et);
        end
    endtask

    initial begin
        int hi;
        int exp_hi;

        // {req, done, exp gnt, exp idx, exp vld, exp tmo}
        // rotation 0,1,2,3,0 back-to-back
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        // pointer skip: serve idx1 so ptr=2, then req=0011
        vecs[6]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[7]  = '{4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[8]  = '{4'b0011, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        // done while idle is ignored
        vecs[10] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        // withdrawal of idx2, then ptr=3 picks idx3 first
        vecs[11] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
        // done + withdrawal together: single release, ptr 3->0 then 0->1
        vecs[14] = '{4'b0111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[15] = '{4'b0111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        // new requests during BUSY do not disturb the owner
        vecs[16] = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[17] = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[18] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        step();
        chk("idle_no_req", 4'b0000, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            req  = vecs[i].req;
            done = vecs[i].done;
            step();
            chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].vld, vecs[i].tmo);
        end
        done = 1'b0;

        // Async reset while idx3 owns (ptr is 2 here).
        req = 4'b1000;
        step();
        chk("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // ptr back at 0: 1010 picks idx1 (ptr=2 would pick idx3)
        req = 4'b1010;
        step();
        chk("post_rst_ptr0", 4'b0010, 2'd1, 1'b1, 1'b0);
        req = 4'b1000;
        step();
        chk("post_rst_idx3", 4'b1000, 2'd3, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk("post_rst_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Hold / timeout with a single persistent requester.
`ifdef RR_ARB_TIMEOUT_EN
        exp_hi = HOLD_MAX;
`else
        exp_hi = 21;
`endif
        req = 4'b0001;
        step();
        chk("hold_first", 4'b0001, 2'd0, 1'b1, 1'b0);
        hi = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (gnt == 4'b0001) begin
                hi++;
            end else begin
                break;
            end
        end
        checks++;
        if (hi != exp_hi) begin
            failures++;
            $display("FAIL hold_len got=%0d exp=%0d", hi, exp_hi);
        end
`ifdef RR_ARB_TIMEOUT_EN
        chk("tmo_pulse", 4'b0000, 2'd0, 1'b0, 1'b1);
        step();
        chk("regrant", 4'b0001, 2'd0, 1'b1, 1'b0);
        hi = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (gnt == 4'b0001) begin
                hi++;
            end else begin
                break;
            end
        end
        checks++;
        if (hi != HOLD_MAX) begin
            failures++;
            $display("FAIL hold_len2 got=%0d exp=%0d", hi, HOLD_MAX);
        end
        chk("tmo_pulse2", 4'b0000, 2'd0, 1'b0, 1'b1);
`else
        chk("no_timeout", 4'b0001, 2'd0, 1'b1, 1'b0);
`endif
        req = 4'b0000;
        step();
        step();
        chk("final_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb.md
# rr_arb

Round-robin arbiter sharing one downstream resource among N requesters. Candidate selection is lowest-index-first search over the request vector, rotated by a registered priority pointer. The block holds the grant until the resource reports completion, the owner withdraws, or an optional hold timeout expires. It sits between requester ports and a shared datapath (bus master, memory port, DMA channel) and drives that resource's mux select.

## Interface
- `N`, default 4: number of requesters; legal range 2..32.
- `HOLD_MAX`, default 64: hold-timeout limit in cycles; used only with `RR_ARB_TIMEOUT_EN`; legal range 1..65535.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active-low; release synchronous to `clk` externally.
- `req`  in  N: level requests; `req[k]` stays high until served or withdrawn.
- `done`  in  1: one-cycle pulse from the resource; ends the current ownership.
- `gnt`  out  N: registered one-hot grant; all-zero when idle.
- `gnt_vld`  out  1: registered; equals OR of `gnt`.
- `gnt_idx`  out  $clog2(N): registered binary index of the granted requester; 0 when idle.
- `tmo`  out  1: registered one-cycle pulse when a grant is revoked by timeout; constant 0 without the macro.

## Operation
- State machine with two states: IDLE and BUSY. Reset state is IDLE.
- Pointer `ptr` is $clog2(N) bits and resets to 0. Requesters with index ≥ `ptr` form the high group; the rest form the low group.
- Candidate selection:
  - Take the lowest set bit of (`req` AND high-group mask).
  - If that is empty, take the lowest set bit of `req`.
  - If `req` is all-zero, there is no candidate.
- IDLE:
  - Candidate present → load `gnt`, `gnt_idx`, `gnt_vld`=1; go to BUSY.
  - No candidate → stay in IDLE.
- BUSY: release occurs when any of these is true in a cycle:
  - `done`=1;
  - `req[gnt_idx]`=0;
  - timeout.
- On release:
  - `ptr` ← (`gnt_idx`+1) mod N. Wrap at N even when N is not a power of two.
  - Re-select the candidate using the new `ptr` and `req` with the released index forced low.
  - Candidate present → new grant next cycle (back-to-back, no idle bubble); stay in BUSY.
  - No candidate → go to IDLE; `gnt` clears.
- Simultaneous release causes (`done` together with withdrawal and/or timeout) count as a single release. `tmo` pulses only when timeout is the sole cause.
- `done` while IDLE is ignored.
- Requests arriving while BUSY have no effect until the next release.
- Only `ptr` is updated by releases.
- Reset asserted mid-operation:
  - `gnt`, `gnt_vld`, `gnt_idx`, `tmo` go to 0 and `ptr` goes to 0 immediately (asynchronously).
  - The hold counter clears.
  - Arbitration restarts from IDLE.

## Timing
- Request to grant: `req` sampled high in IDLE at edge t → `gnt` valid after edge t+1 (1-cycle latency).
- Release to handover: release condition true at edge t → the next owner's `gnt` is visible after t+1, and the old grant is gone in the same cycle. There is never an overlap and never a cycle with two bits set.
- `gnt` is stable while BUSY except at release.
- `tmo` is high exactly one cycle, aligned with the cycle the revoked grant drops.
- Hold counter:
  - Clears on every new grant.
  - Increments each BUSY cycle.
  - Timeout fires when the counter reaches `HOLD_MAX`-1, i.e. at most `HOLD_MAX` cycles of ownership.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - The hold counter ($clog2(HOLD_MAX+1) bits) is compiled in.
  - Timeout acts as a release cause and drives the `tmo` pulse.
- `RR_ARB_TIMEOUT_EN` undefined:
  - No counter logic is built.
  - `tmo` is tied to 0.
  - Ownership ends only on `done` or withdrawal; `HOLD_MAX` is ignored.

## Structure
- Package `rr_arb_pkg` holds:
  - the state enum `rr_arb_state_t` {IDLE, BUSY};
  - a function that converts a one-hot vector to a binary index;
  - a function that builds the high-group mask from `ptr`.
- Sub-module `onehot` (W=N, MSB=0) performs lowest-set-bit isolation. Instantiate it twice: once for the masked request vector, once for the unmasked vector.
- The FSM, pointer and optional hold counter live in `rr_arb`.

## Test plan
- Rotation: N=4, `req`=4'b1111 held high, `done` pulsed on every grant cycle → `gnt_idx` sequence 0,1,2,3,0 with back-to-back grants and no idle cycle.
- Pointer skip: `ptr`=2 (after serving idx 1), `req`=4'b0011 → grant idx 0, then idx 1 after the next `done`, then IDLE once `req`=0.
- Withdrawal: grant idx 2, drop `req[2]` with no `done` → `gnt` clears the next cycle, `ptr`=3, `tmo`=0.
- Timeout (macro on, `HOLD_MAX`=8): `req`=4'b0001 held, no `done` → `gnt[0]` high for exactly 8 cycles, then a `tmo` pulse. Re-grant to idx 0 follows in the next cycle with the counter cleared.
- Simultaneous causes: `done` and `req` drop in the same cycle → a single release, `ptr` advances by one, `tmo`=0.
- Async reset mid-grant: `rst_n` low during BUSY with idx 3 owning → all outputs 0 immediately. After release with `req`=4'b1000, grant idx 3 with `ptr`=0 behaviour.
